cci_mpf_shim_req_limit: RTL and testbench

CCI_MPF_SHIM_REQ_LIMIT -- requirements
Module: cci_mpf_shim_req_limit

---
 rtl/cci_mpf_req_limit_pkg.sv | 26 ++
 rtl/cci_mpf_shim_req_limit_if.sv | 18 +
 rtl/cci_mpf_req_limit_fifo.sv | 55 +++++
 rtl/cci_mpf_shim_req_limit.sv | 127 ++++++++++++
 tb/tb_cci_mpf_shim_req_limit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cci_mpf_req_limit_pkg.sv
// +----------------------------------------------------------------------------+
// | cci_mpf_req_limit_pkg: shared types and helpers for the c0 request limiter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cci_mpf_req_limit_pkg;

  typedef logic [1:0] t_req_limit_state;

  localparam t_req_limit_state RUN     = 2'd0;
  localparam t_req_limit_state STALL   = 2'd1;
  localparam t_req_limit_state DRAIN   = 2'd2;
  localparam t_req_limit_state DRAINED = 2'd3;

  // cl_len field position inside the c0 request header
  localparam int CL_LEN_LSB = 68;

  // Lines consumed by a request: encoding 2 deliberately costs 3
  function automatic logic [2:0] cl_len_cost(input logic [1:0] cl_len);
    return {1'b0, cl_len} + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cci_mpf_shim_req_limit_if.sv
// +----------------------------------------------------------------------------+
// | cci_mpf_shim_req_limit_if: c0 request channel (valid/hdr/almost_full)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cci_mpf_shim_req_limit_if #(
  parameter int HDR_WIDTH = 74
);
  logic                 c0_valid;
  logic [HDR_WIDTH-1:0] c0_hdr;
  logic                 c0_almost_full;

  modport master (output c0_valid, output c0_hdr, input  c0_almost_full);
  modport slave  (input  c0_valid, input  c0_hdr, output c0_almost_full);
endinterface

`default_nettype wire

// File: rtl/cci_mpf_req_limit_fifo.sv
// +----------------------------------------------------------------------------+
// | cci_mpf_req_limit_fifo: synchronous ingress FIFO with occupancy output     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cci_mpf_req_limit_fifo #(
  parameter int WIDTH = 74,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && (r_count != C_FULL);
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/cci_mpf_shim_req_limit.sv
// +----------------------------------------------------------------------------+
// | cci_mpf_shim_req_limit: caps outstanding c0 read lines, with drain control |
// | Optional: CCI_MPF_SHIM_REQ_LIMIT_STATS_EN enables stat_stall_cycles        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cci_mpf_shim_req_limit
  import cci_mpf_req_limit_pkg::*;
#(
  parameter int MAX_ACTIVE_REQS = 128,
  parameter int HDR_WIDTH       = 74,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  cci_mpf_shim_req_limit_if.slave             afu,
  cci_mpf_shim_req_limit_if.master            fiu,
  input  logic                                fiu_rx_rd_valid,
  input  logic [$clog2(MAX_ACTIVE_REQS):0]    cfg_max_active,
  input  logic                                drain_req,
  output logic                                drain_done,
  output logic [$clog2(MAX_ACTIVE_REQS):0]    stat_active,
  output logic [31:0]                         stat_stall_cycles,
  output logic                                err_underflow
);
  localparam int AW = $clog2(MAX_ACTIVE_REQS) + 1;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = AW + 3;
  localparam logic [AW-1:0] C_MAX   = AW'(MAX_ACTIVE_REQS);
  localparam logic [OW-1:0] C_DEPTH = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] C_AF    = OW'(FIFO_DEPTH - 2);

  t_req_limit_state     r_state, w_state_next;
  logic [AW-1:0]        r_active, w_active_next, w_limit;
  logic                 r_err, r_afu_af, r_fiu_valid;
  logic [HDR_WIDTH-1:0] r_fiu_hdr, w_head;
  logic [OW-1:0]        w_occ, w_occ_next;
  logic [2:0]           w_cost;
  logic                 w_empty, w_push, w_ready, w_fits, w_issue, w_underflow;

  cci_mpf_req_limit_fifo #(
    .WIDTH (HDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (afu.c0_valid),
    .din   (afu.c0_hdr),
    .pop   (w_issue),
    .dout  (w_head),
    .empty (w_empty),
    .count (w_occ)
  );

  assign w_limit = (cfg_max_active == '0 || cfg_max_active > C_MAX) ? C_MAX : cfg_max_active;
  assign w_cost  = cl_len_cost(w_head[CL_LEN_LSB +: 2]);
  assign w_fits  = ({3'b000, r_active} + SW'(w_cost)) <= {3'b000, w_limit};
  assign w_ready = !w_empty && !fiu.c0_almost_full;
  assign w_issue = (r_state == RUN) && w_ready && w_fits;

  // A beat with nothing outstanding is flagged and otherwise ignored
  assign w_underflow   = fiu_rx_rd_valid && (r_active == '0);
  assign w_active_next = r_active + (w_issue ? AW'(w_cost) : AW'(0))
                         - ((fiu_rx_rd_valid && !w_underflow) ? AW'(1) : AW'(0));

  assign w_push     = afu.c0_valid && (w_occ != C_DEPTH);
  assign w_occ_next = w_occ + OW'(w_push) - OW'(w_issue);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (drain_req) w_state_next = DRAIN;
               else if (w_ready && !w_fits) w_state_next = STALL;
      STALL:   if (drain_req) w_state_next = DRAIN;
               else if (w_fits) w_state_next = RUN;
      DRAIN:   if (w_active_next == '0) w_state_next = DRAINED;
      DRAINED: if (!drain_req) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_active    <= '0;
      r_err       <= 1'b0;
      r_afu_af    <= 1'b0;
      r_fiu_valid <= 1'b0;
      r_fiu_hdr   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_active    <= w_active_next;
      r_err       <= r_err | w_underflow;
      // Based on next occupancy so the AFU may still send two more safely
      r_afu_af    <= (w_occ_next >= C_AF);
      r_fiu_valid <= w_issue;
      if (w_issue) r_fiu_hdr <= w_head;
    end
  end

`ifdef CCI_MPF_SHIM_REQ_LIMIT_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (r_state == STALL && r_stall_cycles != 32'hFFFF_FFFF) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stat_stall_cycles = r_stall_cycles;
`else
  assign stat_stall_cycles = 32'd0;
`endif

  assign afu.c0_almost_full = r_afu_af;
  assign fiu.c0_valid       = r_fiu_valid;
  assign fiu.c0_hdr         = r_fiu_hdr;
  assign drain_done         = (r_state == DRAINED);
  assign stat_active        = r_active;
  assign err_underflow      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cci_mpf_shim_req_limit.sv
// +----------------------------------------------------------------------------+
// | tb_cci_mpf_shim_req_limit: directed + random bench against a queue model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cci_mpf_shim_req_limit;
  import cci_mpf_req_limit_pkg::*;

  localparam int MAX = 8;
  localparam int HW  = 74;
  localparam int FD  = 4;
  localparam int AW  = $clog2(MAX) + 1;
`ifdef CCI_MPF_SHIM_REQ_LIMIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int S_RUN = 0, S_STALL = 1, S_DRAIN = 2, S_DRAINED = 3;

  logic          clk;
  logic          reset;
  logic          fiu_rx_rd_valid;
  logic [AW-1:0] cfg_max_active;
  logic          drain_req;
  logic          drain_done;
  logic [AW-1:0] stat_active;
  logic [31:0]   stat_stall_cycles;
  logic          err_underflow;

  cci_mpf_shim_req_limit_if #(.HDR_WIDTH(HW)) afu_if ();
  cci_mpf_shim_req_limit_if #(.HDR_WIDTH(HW)) fiu_if ();

  cci_mpf_shim_req_limit #(
    .MAX_ACTIVE_REQS (MAX),
    .HDR_WIDTH       (HW),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .afu               (afu_if),
    .fiu               (fiu_if),
    .fiu_rx_rd_valid   (fiu_rx_rd_valid),
    .cfg_max_active    (cfg_max_active),
    .drain_req         (drain_req),
    .drain_done        (drain_done),
    .stat_active       (stat_active),
    .stat_stall_cycles (stat_stall_cycles),
    .err_underflow     (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending queue, outstanding line count, drain state
  logic [HW-1:0] m_q[$];
  int            m_act;
  int            m_st;
  bit            m_af, m_fv, m_err;
  logic [HW-1:0] m_fh;
  longint        m_stall;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input int cl);
    logic [HW-1:0] x;
    x = HW'({$urandom, $urandom, $urandom});
    x[CL_LEN_LSB +: 2] = 2'(cl);
    return x;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_act = 0; m_st = S_RUN; m_af = 0; m_fv = 0; m_err = 0; m_fh = '0; m_stall = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    afu_if.c0_valid = 1'b0; afu_if.c0_hdr = '0; fiu_if.c0_almost_full = 1'b0;
    fiu_rx_rd_valid = 1'b0; drain_req = 1'b0; cfg_max_active = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk("rst_afu_af", afu_if.c0_almost_full, 0);
    chk("rst_fiu_valid", fiu_if.c0_valid, 0);
    chk("rst_fiu_hdr", fiu_if.c0_hdr, 0);
    chk("rst_active", stat_active, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_stall", stat_stall_cycles, 0);
  endtask

  // Entered and left at a falling edge: compare, drive, step DUT and model
  task automatic cycle(input bit v, input logic [HW-1:0] h, input bit faf,
                       input bit beat, input int cfg, input bit drn);
    int  lim, cost, n_act;
    bit  ready, fits, iss, under;
    chk("fiu_valid", fiu_if.c0_valid, m_fv);
    chk("fiu_hdr", fiu_if.c0_hdr, m_fh);
    chk("afu_af", afu_if.c0_almost_full, m_af);
    chk("active", stat_active, m_act);
    chk("drain_done", drain_done, m_st == S_DRAINED);
    chk("err", err_underflow, m_err);
    chk("stall", stat_stall_cycles, m_stall);

    afu_if.c0_valid = v; afu_if.c0_hdr = h; fiu_if.c0_almost_full = faf;
    fiu_rx_rd_valid = beat; cfg_max_active = AW'(cfg); drain_req = drn;

    lim   = (cfg == 0 || cfg > MAX) ? MAX : cfg;
    cost  = (m_q.size() > 0) ? int'(m_q[0][CL_LEN_LSB +: 2]) + 1 : 0;
    ready = (m_q.size() > 0) && !faf;
    fits  = (m_act + cost) <= lim;
    iss   = (m_st == S_RUN) && ready && fits;
    under = beat && (m_act == 0);
    if (under) m_err = 1;
    n_act = m_act + (iss ? cost : 0) - ((beat && !under) ? 1 : 0);
    if (STATS && m_st == S_STALL && m_stall < 64'hFFFF_FFFF) m_stall++;
    case (m_st)
      S_RUN:     if (drn) m_st = S_DRAIN; else if (ready && !fits) m_st = S_STALL;
      S_STALL:   if (drn) m_st = S_DRAIN; else if (fits) m_st = S_RUN;
      S_DRAIN:   if (n_act == 0) m_st = S_DRAINED;
      default:   if (!drn) m_st = S_RUN;
    endcase
    m_fv = iss;
    if (iss) m_fh = m_q.pop_front();
    if (v && m_q.size() < FD) m_q.push_back(h);
    m_af  = m_q.size() >= FD - 2;
    m_act = n_act;

    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] s1;
  int          rcfg;
  bit          rdrn;

  initial begin
    reset = 1'b1;
    do_reset();

    // Limit 4: four single-line reads issue, the fifth waits in STALL
    for (int i = 0; i < 5; i++) cycle(1, mk_hdr(0), 0, 0, 4, 0);
    repeat (3) cycle(0, '0, 0, 0, 4, 0);
    chk("lim4_active", stat_active, 4);
    s1 = stat_stall_cycles;
    repeat (3) cycle(0, '0, 0, 0, 4, 0);
    chk("stall_inc", stat_stall_cycles - s1, STATS ? 3 : 0);

    // Three lines out, two-line head blocked until one beat returns
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, mk_hdr(0), 0, 0, 4, 0);
    cycle(1, mk_hdr(1), 0, 0, 4, 0);
    repeat (3) cycle(0, '0, 0, 0, 4, 0);
    chk("blocked_active", stat_active, 3);
    cycle(0, '0, 0, 1, 4, 0);
    repeat (3) cycle(0, '0, 0, 0, 4, 0);
    chk("unblocked_active", stat_active, 4);

    // Issue and response in the same cycle
    do_reset();
    cycle(1, mk_hdr(0), 0, 0, 4, 0);
    cycle(1, mk_hdr(0), 0, 0, 4, 0);
    cycle(0, '0, 0, 0, 4, 0);
    cycle(1, mk_hdr(0), 0, 0, 4, 0);
    cycle(0, '0, 0, 1, 4, 0);
    chk("same_cycle_active", stat_active, 2);

    // Drain with three outstanding, more requests queued meanwhile
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, mk_hdr(0), 0, 0, 8, 0);
    repeat (2) cycle(0, '0, 0, 0, 8, 0);
    for (int i = 0; i < 2; i++) cycle(1, mk_hdr(0), 0, 0, 8, 1);
    repeat (2) cycle(0, '0, 0, 0, 8, 1);
    chk("drain_hold", stat_active, 3);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1, 8, 1);
    chk("drain_done_rise", drain_done, 1);
    repeat (5) cycle(0, '0, 0, 0, 8, 0);
    chk("drain_resume", stat_active, 2);

    // Back-to-back into a blocked pipeline
    do_reset();
    cycle(1, mk_hdr(0), 1, 0, 8, 0);
    cycle(1, mk_hdr(0), 1, 0, 8, 0);
    chk("af_after2", afu_if.c0_almost_full, 1);
    cycle(1, mk_hdr(0), 1, 0, 8, 0);
    cycle(1, mk_hdr(0), 1, 0, 8, 0);
    repeat (8) cycle(0, '0, 0, 0, 8, 0);
    chk("release_active", stat_active, 4);

    // Underflow is sticky until reset
    do_reset();
    cycle(0, '0, 0, 1, 8, 0);
    cycle(0, '0, 0, 0, 8, 0);
    chk("underflow_err", err_underflow, 1);
    chk("underflow_active", stat_active, 0);
    do_reset();

    // Random traffic, with one reset in the middle
    rcfg = 4; rdrn = 0;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      if ($urandom_range(0, 19) == 0) rcfg = $urandom_range(0, 15);
      if ($urandom_range(0, 39) == 0) rdrn = !rdrn;
      cycle(!m_af && ($urandom_range(0, 2) != 0), mk_hdr($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, (m_act > 0) && ($urandom_range(0, 1) == 1),
            rcfg, rdrn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
